led_blink_array: RTL and testbench

Parametrised multi-channel LED blinker driving board status LEDs from one clock domain. Each channel has a runtime-programmable mode, period and on-width, counted in prescaler ticks, and a pseudo-random-interval mode fed by a shared LFSR. It sits between the system tick generator and the LED pins and replaces fixed-interval per-LED blink logic.

---
 rtl/led_blink_pkg.sv | 21 ++
 rtl/blink_channel.sv | 113 +++++++++++
 rtl/led_blink_array.sv | 80 ++++++++
 tb/tb_led_blink_array.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_blink_pkg.sv
// Shared types and constants for the LED blinker array: channel modes and
// the Galois LFSR used for pseudo-random blink intervals.
package led_blink_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_ON     = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_RANDOM = 2'd3
  } mode_e;

  localparam int                LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // One Galois step: shift right, fold the taps back in when a 1 falls out.
  // A non-zero state never maps to zero, so the sequence cannot lock up.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/blink_channel.sv
// One LED channel: holds its own mode / period / on-width, runs the tick
// counter, reloads the randomised period at each wrap and registers the LED.
module blink_channel
  import led_blink_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int RAND_W = 8
) (
  input  logic              clk,
  input  logic              rstbtn,
  input  logic              i_wr,
  input  mode_e             i_mode,
  input  logic [CNT_W-1:0]  i_period,
  input  logic [CNT_W-1:0]  i_on,
  input  logic              i_tick,
  input  logic [RAND_W-1:0] i_rand,
  output logic              o_led
);

  // Period plus random offset, clamped to the largest counter value so a
  // long base period never wraps around into a short one.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0]  a,
                                               input logic [RAND_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, {(CNT_W-RAND_W){1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  mode_e            r_mode;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_on;
  logic [CNT_W-1:0] r_eff;
  logic [CNT_W-1:0] r_cnt;
  logic             r_led;

  logic [CNT_W:0]   w_cnt_inc;
  logic             w_wrap;
  logic             w_stall;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_led_next;
  logic             w_led_wr;
  logic [CNT_W-1:0] w_reload;

  // Counter is widened by one bit so cnt + 1 cannot overflow before the
  // compare; an effective period of zero always "wraps" and keeps cnt at 0.
  assign w_cnt_inc  = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_wrap     = (w_cnt_inc >= {1'b0, r_eff});
  assign w_stall    = (r_eff == '0);
  assign w_cnt_next = w_wrap ? '0 : w_cnt_inc[CNT_W-1:0];
  assign w_led_next = !w_stall && (w_cnt_next < r_on);
  assign w_reload   = sat_add(r_period, i_rand);

  // LED value straight after a write: the mode evaluated at cnt = 0.
  always_comb begin
    w_led_wr = 1'b0;
    case (i_mode)
      MODE_OFF:    w_led_wr = 1'b0;
      MODE_ON:     w_led_wr = 1'b1;
      MODE_BLINK,
      MODE_RANDOM: w_led_wr = (i_on != '0) && (i_period != '0);
      default:     w_led_wr = 1'b0;
    endcase
  end

  // Channel state: reset clears everything, a write beats a tick, and a
  // tick advances the counter according to the latched mode.
  always_ff @(posedge clk) begin
    if (rstbtn) begin
      r_mode   <= MODE_OFF;
      r_period <= '0;
      r_on     <= '0;
      r_eff    <= '0;
      r_cnt    <= '0;
      r_led    <= 1'b0;
    end else if (i_wr) begin
      r_mode   <= i_mode;
      r_period <= i_period;
      r_on     <= i_on;
      r_eff    <= i_period;
      r_cnt    <= '0;
      r_led    <= w_led_wr;
    end else if (i_tick) begin
      case (r_mode)
        MODE_OFF: begin
          r_cnt <= '0;
          r_led <= 1'b0;
        end
        MODE_ON: begin
          r_cnt <= '0;
          r_led <= 1'b1;
        end
        MODE_BLINK: begin
          r_cnt <= w_cnt_next;
          r_led <= w_led_next;
        end
        MODE_RANDOM: begin
          r_cnt <= w_cnt_next;
          r_led <= w_led_next;
          if (w_wrap) begin
            r_eff <= w_reload;
          end
        end
        default: begin
          r_cnt <= '0;
          r_led <= 1'b0;
        end
      endcase
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/led_blink_array.sv
// Multi-channel LED blinker: decodes configuration writes onto the channel
// array, flags writes to channels that do not exist, and runs the shared
// LFSR that feeds the pseudo-random blink mode.
module led_blink_array
  import led_blink_pkg::*;
#(
  parameter int          NUM_CH    = 3,
  parameter int          CNT_W     = 16,
  parameter int          RAND_W    = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rstbtn,
  input  logic              tick_en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_on,
  output logic [NUM_CH-1:0] led,
  output logic              cfg_err
);

  // A zero seed would freeze the LFSR, so it is quietly replaced by 1.
  localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? 16'h0001 : LFSR_SEED;
  localparam logic [CH_W:0]     NUM_CH_L = (CH_W+1)'(NUM_CH);

  logic [LFSR_W-1:0] r_lfsr;
  logic              r_cfg_err;
  logic              w_bad_wr;
  logic [NUM_CH-1:0] w_wr;
  logic [NUM_CH-1:0] w_led;
  mode_e             w_mode;

  assign w_mode   = mode_e'(cfg_mode);
  assign w_bad_wr = cfg_we && ({1'b0, cfg_ch} >= NUM_CH_L);

  // Shared LFSR advances once per prescaler tick; all channels see the
  // same value in a given tick.
  always_ff @(posedge clk) begin
    if (rstbtn) begin
      r_lfsr <= SEED_EFF;
    end else if (tick_en) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  // Bad-address flag is a single-cycle pulse following the offending write.
  always_ff @(posedge clk) begin
    if (rstbtn) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_bad_wr;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_wr[g] = cfg_we && (cfg_ch == CH_W'(g));

    blink_channel #(
      .CNT_W  (CNT_W),
      .RAND_W (RAND_W)
    ) u_ch (
      .clk      (clk),
      .rstbtn   (rstbtn),
      .i_wr     (w_wr[g]),
      .i_mode   (w_mode),
      .i_period (cfg_period),
      .i_on     (cfg_on),
      .i_tick   (tick_en),
      .i_rand   (r_lfsr[RAND_W-1:0]),
      .o_led    (w_led[g])
    );
  end

  assign led     = w_led;
  assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_led_blink_array.sv
// Directed bench for led_blink_array: a 3-channel default instance plus a
// narrow 1-channel instance used to reach period saturation quickly.
module tb_led_blink_array;

  logic        clk;
  logic        rstbtn;
  logic        tick_en;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_period;
  logic [15:0] cfg_on;
  logic [2:0]  led;
  logic        cfg_err;

  logic        d2_tick;
  logic        d2_we;
  logic [0:0]  d2_ch;
  logic [1:0]  d2_mode;
  logic [7:0]  d2_period;
  logic [7:0]  d2_on;
  logic [0:0]  d2_led;
  logic        d2_err;

  logic [15:0] m_lfsr;
  int          checks;
  int          errors;

  led_blink_array dut (
    .clk        (clk),
    .rstbtn     (rstbtn),
    .tick_en    (tick_en),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .cfg_on     (cfg_on),
    .led        (led),
    .cfg_err    (cfg_err)
  );

  led_blink_array #(.NUM_CH(1), .CNT_W(8), .RAND_W(4)) dut2 (
    .clk        (clk),
    .rstbtn     (rstbtn),
    .tick_en    (d2_tick),
    .cfg_we     (d2_we),
    .cfg_ch     (d2_ch),
    .cfg_mode   (d2_mode),
    .cfg_period (d2_period),
    .cfg_on     (d2_on),
    .led        (d2_led),
    .cfg_err    (d2_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference LFSR for the 3-channel instance.
  always @(posedge clk) begin
    if (rstbtn) m_lfsr <= 16'hACE1;
    else if (tick_en) m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] mode,
                    input logic [15:0] per, input logic [15:0] on_w);
    cfg_we = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_period = per; cfg_on = on_w;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic tick();
    tick_en = 1'b1;
    step();
    tick_en = 1'b0;
  endtask

  // Ticks until channel 2 lights (on-width 1 means lit only at cnt 0);
  // returns the tick count and the LFSR value used on the wrapping tick.
  task automatic measure_ch2(output int n, output logic [15:0] lb);
    n = 0;
    lb = m_lfsr;
    do begin
      lb = m_lfsr;
      tick();
      n++;
    end while (led[2] !== 1'b1 && n < 400);
  endtask

  initial begin
    int n;
    logic [15:0] lb;
    checks = 0; errors = 0;
    rstbtn = 1'b1; tick_en = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0;
    cfg_period = '0; cfg_on = '0;
    d2_tick = 1'b0; d2_we = 1'b0; d2_ch = '0; d2_mode = '0; d2_period = '0; d2_on = '0;
    step(); step();
    chk("reset_led", {29'd0, led}, 32'd0);
    chk("reset_err", {31'd0, cfg_err}, 32'd0);
    rstbtn = 1'b0;
    tick(); tick();
    chk("off_after_reset", {29'd0, led}, 32'd0);

    // ch0 BLINK period 10 on 1, tick every clk
    wr(2'd0, 2'd2, 16'd10, 16'd1);
    chk("ch0_first_high", {31'd0, led[0]}, 32'd1);
    chk("ch0_no_err", {31'd0, cfg_err}, 32'd0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("ch0_blink", {31'd0, led[0]}, (k % 10 == 0) ? 32'd1 : 32'd0);
    end

    // ch1 BLINK period 5 on 2, tick every 4th clk
    wr(2'd1, 2'd2, 16'd5, 16'd2);
    chk("ch1_first_high", {31'd0, led[1]}, 32'd1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("ch1_tick", {31'd0, led[1]}, ((k % 5) < 2) ? 32'd1 : 32'd0);
      step(); step(); step();
      chk("ch1_hold", {31'd0, led[1]}, ((k % 5) < 2) ? 32'd1 : 32'd0);
    end

    // ch2 RANDOM period 4 on 1: intervals follow 4 + LFSR low byte
    wr(2'd2, 2'd3, 16'd4, 16'd1);
    chk("ch2_first_high", {31'd0, led[2]}, 32'd1);
    measure_ch2(n, lb);
    chk("rand_int0", n, 32'd4);
    for (int k = 1; k <= 3; k++) begin
      logic [15:0] prev;
      prev = lb;
      measure_ch2(n, lb);
      chk("rand_int", n, 32'd4 + {24'd0, prev[7:0]});
    end

    // period 0 stalls
    wr(2'd0, 2'd2, 16'd0, 16'd3);
    chk("p0_wr", {31'd0, led[0]}, 32'd0);
    repeat (3) tick();
    chk("p0_tick", {31'd0, led[0]}, 32'd0);
    // on >= period -> solid 1
    wr(2'd0, 2'd2, 16'd5, 16'd7);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("solid1", {31'd0, led[0]}, 32'd1);
    end
    // ON / OFF ignore ticks
    wr(2'd1, 2'd1, 16'd3, 16'd1);
    repeat (4) tick();
    chk("mode_on", {31'd0, led[1]}, 32'd1);
    wr(2'd1, 2'd0, 16'd3, 16'd1);
    repeat (4) tick();
    chk("mode_off", {31'd0, led[1]}, 32'd0);
    // RANDOM with maximal period: no early wrap
    wr(2'd2, 2'd3, 16'hFFFF, 16'd2);
    chk("max_wr", {31'd0, led[2]}, 32'd1);
    tick();
    chk("max_t1", {31'd0, led[2]}, 32'd1);
    tick();
    chk("max_t2", {31'd0, led[2]}, 32'd0);
    repeat (3) tick();
    chk("max_t5", {29'd0, led}, 32'b001);

    // write to nonexistent channel 3
    wr(2'd3, 2'd1, 16'd1, 16'd1);
    chk("err_pulse", {31'd0, cfg_err}, 32'd1);
    chk("err_nochange", {29'd0, led}, 32'b001);
    step();
    chk("err_once", {31'd0, cfg_err}, 32'd0);
    chk("err_nochange2", {29'd0, led}, 32'b001);

    // write + tick same cycle: write wins on ch0, ch1 still ticks
    wr(2'd1, 2'd2, 16'd2, 16'd1);
    chk("ch1_p2", {31'd0, led[1]}, 32'd1);
    tick_en = 1'b1;
    wr(2'd0, 2'd2, 16'd3, 16'd1);
    tick_en = 1'b0;
    chk("wt_0", {29'd0, led}, 32'b001);
    tick();
    chk("wt_1", {29'd0, led}, 32'b010);
    tick();
    chk("wt_2", {29'd0, led}, 32'b000);
    tick();
    chk("wt_3", {29'd0, led}, 32'b011);

    // reset overrides a simultaneous write and tick
    rstbtn = 1'b1; tick_en = 1'b1;
    wr(2'd1, 2'd1, 16'd1, 16'd1);
    rstbtn = 1'b0; tick_en = 1'b0;
    chk("rst_led", {29'd0, led}, 32'd0);
    chk("rst_err", {31'd0, cfg_err}, 32'd0);
    repeat (3) tick();
    chk("rst_stay_off", {29'd0, led}, 32'd0);
    wr(2'd2, 2'd3, 16'd2, 16'd1);
    chk("rst_rand_wr", {29'd0, led}, 32'b100);
    measure_ch2(n, lb);
    chk("rst_rand0", n, 32'd2);
    begin
      logic [15:0] prev;
      prev = lb;
      measure_ch2(n, lb);
      chk("rst_rand1", n, 32'd2 + {24'd0, prev[7:0]});
    end

    // narrow instance: period 255 + random must saturate to 255
    d2_we = 1'b1; d2_mode = 2'd3; d2_period = 8'hFF; d2_on = 8'd1;
    step();
    d2_we = 1'b0;
    chk("sat_wr", {31'd0, d2_led}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        d2_tick = 1'b1; step(); d2_tick = 1'b0; n++;
      end while (d2_led[0] !== 1'b1 && n < 400);
      chk("sat_interval", n, 32'd255);
    end
    chk("sat_err", {31'd0, d2_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
